// File: rtl/caja_pkg.sv
// Shared definitions for the music-box blocks: system clock rate, one-hot
// key patterns for the seven notes of the `teclas` bus, and the state
// encoding of the melody sequencer.
package caja_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // One-hot key patterns; bit 0 is DO, bit 6 is SI.
  localparam logic [6:0] SILENCIO = 7'b0000000;
  localparam logic [6:0] DO       = 7'b0000001;
  localparam logic [6:0] RE       = 7'b0000010;
  localparam logic [6:0] MI       = 7'b0000100;
  localparam logic [6:0] FA       = 7'b0001000;
  localparam logic [6:0] SOL      = 7'b0010000;
  localparam logic [6:0] LA       = 7'b0100000;
  localparam logic [6:0] SI       = 7'b1000000;

  // Sequencer states: idle, sounding an entry, silent gap after an entry.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TOCA  = 2'd1,
    PAUSA = 2'd2
  } estado_t;

endpackage

// File: rtl/reproductor_melodia_gen_tick.sv
// gen_tick: free-running prescaler producing a one-cycle tick every
// TICK_CYC clock cycles.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   clr   - synchronous clear; restarts the period from zero
//   tick  - high for one cycle at the end of each period
module gen_tick #(
  parameter int TICK_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  logic [PW-1:0] pcnt;

  assign tick = (pcnt == PW'(TICK_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt <= '0;
    end else if (clr || tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

endmodule

// File: rtl/reproductor_melodia.sv
// reproductor_melodia: melody sequencer feeding the `teclas` key bus of the
// tone generator. Plays a writable table of (note, duration) entries, with
// durations counted in prescaler ticks and an optional silent gap after
// every entry so repeated notes retrigger.
// Ports:
//   clk, reset        - system clock, asynchronous active-low reset
//   wr_en/addr/nota/dur - table write port, accepted on any cycle
//   largo             - number of valid entries (clamped to N_NOTAS)
//   play, stop        - start / abort pulses (stop has priority)
//   loop              - restart at entry 0 after the last entry
//   teclas            - registered key pattern of the current entry
//   busy              - playing (TOCA or PAUSA)
//   fin               - one-cycle pulse at the natural end of a melody
//   idx               - entry currently playing
module reproductor_melodia
  import caja_pkg::*;
#(
  parameter int TICK_CYC  = 50000,
  parameter int N_NOTAS   = 16,
  parameter int ADDR_W    = 4,
  parameter int DUR_W     = 12,
  parameter int GAP_TICKS = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_nota,
  input  logic [DUR_W-1:0]  wr_dur,
  input  logic [ADDR_W:0]   largo,
  input  logic              play,
  input  logic              stop,
  input  logic              loop,
  output logic [6:0]        teclas,
  output logic              busy,
  output logic              fin,
  output logic [ADDR_W-1:0] idx
);

  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  logic [6:0]       tab_nota [N_NOTAS];
  logic [DUR_W-1:0] tab_dur  [N_NOTAS];

  estado_t          state, state_n;
  logic [6:0]       teclas_n;
  logic [ADDR_W-1:0] idx_n, load_addr;
  logic [DUR_W-1:0] dcnt, dcnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic             fin_n;
  logic             load, advance, tick;
  logic [ADDR_W:0]  largo_ef, idx_sig;

  // Table storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tab_nota[wr_addr] <= wr_nota;
      tab_dur[wr_addr]  <= wr_dur;
    end
  end

  gen_tick #(
    .TICK_CYC(TICK_CYC)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .clr  (load),
    .tick (tick)
  );

  assign largo_ef = (largo > (ADDR_W+1)'(N_NOTAS)) ? (ADDR_W+1)'(N_NOTAS) : largo;
  assign idx_sig  = {1'b0, idx} + (ADDR_W+1)'(1);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      teclas <= '0;
      idx    <= '0;
      dcnt   <= '0;
      gcnt   <= '0;
      fin    <= 1'b0;
    end else begin
      state  <= state_n;
      teclas <= teclas_n;
      idx    <= idx_n;
      dcnt   <= dcnt_n;
      gcnt   <= gcnt_n;
      fin    <= fin_n;
    end
  end

  always_comb begin
    state_n   = state;
    teclas_n  = teclas;
    idx_n     = idx;
    dcnt_n    = dcnt;
    gcnt_n    = gcnt;
    fin_n     = 1'b0;
    load      = 1'b0;
    load_addr = '0;
    advance   = 1'b0;

    if (stop) begin
      state_n  = IDLE;
      teclas_n = '0;
      idx_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (play && (largo_ef != '0)) begin
            load = 1'b1;
          end
        end
        TOCA: begin
          // dcnt never holds 0 while sounding, so the tick seen at 1 is the last.
          if (tick) begin
            if (dcnt == DUR_W'(1)) begin
              if (GAP_TICKS > 0) begin
                state_n  = PAUSA;
                teclas_n = '0;
                gcnt_n   = GW'(GAP_TICKS);
              end else begin
                advance = 1'b1;
              end
            end else begin
              dcnt_n = dcnt - DUR_W'(1);
            end
          end
        end
        PAUSA: begin
          if (tick) begin
            if (gcnt == GW'(1)) begin
              advance = 1'b1;
            end else begin
              gcnt_n = gcnt - GW'(1);
            end
          end
        end
        default: begin
          state_n  = IDLE;
          teclas_n = '0;
        end
      endcase

      if (advance) begin
        if (idx_sig < largo_ef) begin
          load      = 1'b1;
          load_addr = idx + ADDR_W'(1);
        end else if (loop) begin
          load = 1'b1;
        end else begin
          state_n  = IDLE;
          teclas_n = '0;
          fin_n    = 1'b1;
        end
      end
    end

    if (load) begin
      state_n  = TOCA;
      idx_n    = load_addr;
      teclas_n = tab_nota[load_addr];
      dcnt_n   = (tab_dur[load_addr] == '0) ? DUR_W'(1) : tab_dur[load_addr];
    end
  end

endmodule
